// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } bus_state_e;

  // Clears the byte-offset bits to form a word address.
  localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/bus_wait_timer.sv
// Counts consecutive stalled bus cycles and flags the cycle that hits the limit.
module bus_wait_timer #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_stall,
  output logic o_expire_c
);

  localparam int unsigned CW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

  logic [CW-1:0] r_count;

  // Stalled-cycle counter; saturates at the last tolerated count.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (!i_stall) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The current stalled cycle is the WAIT_LIMIT-th one; zero limit never expires.
  assign o_expire_c = (WAIT_LIMIT != 0) && i_stall && !i_clear && (r_count == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction-fetch and data ports onto a single waitrequest-style bus.
module mem_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  bus_state_e  r_state;
  bus_state_e  w_state_nxt;

  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_if_rdata;
  logic        r_if_done;
  logic        r_if_err;
  logic [31:0] r_d_rdata;
  logic        r_d_done;
  logic        r_d_err;

  logic        w_active;
  logic        w_expire;
  logic        w_accept_d;
  logic        w_accept_if;
  logic        w_misalign;
  logic        w_complete;
  logic        w_abort;

  assign w_active = (r_state != ST_IDLE);

  bus_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (!w_active),
    .i_stall    (waitrequest),
    .o_expire_c (w_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle event decode; a port is blocked while its own done is high.
  always_comb begin
    w_state_nxt = r_state;
    w_accept_d  = 1'b0;
    w_accept_if = 1'b0;
    w_misalign  = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (d_req && !r_d_done) begin
          w_accept_d  = 1'b1;
          w_state_nxt = ST_DATA;
        end else if (if_req && !r_if_done) begin
          if (if_addr[1:0] != 2'b00) begin
            w_misalign = 1'b1;
          end else begin
            w_accept_if = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH, ST_DATA: begin
        if (!waitrequest) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Holding registers, bus strobes and port result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_if_rdata <= '0;
      r_if_done  <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_rdata  <= '0;
      r_d_done   <= 1'b0;
      r_d_err    <= 1'b0;
    end else begin
      r_if_done <= 1'b0;
      r_if_err  <= 1'b0;
      r_d_done  <= 1'b0;
      r_d_err   <= 1'b0;

      if (w_accept_d) begin
        r_addr  <= d_addr;
        r_we    <= d_we;
        r_wdata <= d_wdata;
        r_be    <= d_be;
        r_read  <= !d_we;
        r_write <= d_we;
      end

      if (w_accept_if) begin
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_be    <= 4'b1111;
        r_read  <= 1'b1;
        r_write <= 1'b0;
      end

      if (w_misalign) begin
        r_if_done  <= 1'b1;
        r_if_err   <= 1'b1;
        r_if_rdata <= '0;
      end

      if (w_complete) begin
        r_read  <= 1'b0;
        r_write <= 1'b0;
        if (r_state == ST_FETCH) begin
          r_if_done  <= 1'b1;
          r_if_rdata <= readdata;
        end else begin
          r_d_done <= 1'b1;
          if (!r_we) begin
            r_d_rdata <= readdata;
          end
        end
      end

      if (w_abort) begin
        r_read  <= 1'b0;
        r_write <= 1'b0;
        if (r_state == ST_FETCH) begin
          r_if_done  <= 1'b1;
          r_if_err   <= 1'b1;
          r_if_rdata <= '0;
        end else begin
          r_d_done  <= 1'b1;
          r_d_err   <= 1'b1;
          r_d_rdata <= '0;
        end
      end
    end
  end

  // Bus and port outputs come straight from registers.
  assign address    = r_addr & WORD_ADDR_MASK;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_wdata;
  assign byteenable = r_be;
  assign busy       = w_active;
  assign if_rdata   = r_if_rdata;
  assign if_done    = r_if_done;
  assign if_err     = r_if_err;
  assign d_rdata    = r_d_rdata;
  assign d_done     = r_d_done;
  assign d_err      = r_d_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a short timeout limit.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        busy;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  int total;
  int bad;

  mem_bus_arbiter #(
    .WAIT_LIMIT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_done     (if_done),
    .if_err      (if_err),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_rdata     (d_rdata),
    .d_done      (d_done),
    .d_err       (d_err),
    .busy        (busy),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    if_req      = 1'b0;
    if_addr     = '0;
    d_req       = 1'b0;
    d_we        = 1'b0;
    d_addr      = '0;
    d_wdata     = '0;
    d_be        = '0;
    waitrequest = 1'b0;
    readdata    = '0;

    // Reset state
    step();
    step();
    chk1 ("rst_busy",    busy,     1'b0);
    chk1 ("rst_read",    read,     1'b0);
    chk1 ("rst_write",   write,    1'b0);
    chk1 ("rst_if_done", if_done,  1'b0);
    chk1 ("rst_d_done",  d_done,   1'b0);
    chk32("rst_if_rd",   if_rdata, 32'h0);
    chk32("rst_d_rd",    d_rdata,  32'h0);
    chk32("rst_addr",    address,  32'h0);
    reset = 1'b0;
    step();

    // Zero-wait aligned fetch
    if_req   = 1'b1;
    if_addr  = 32'h0000_1000;
    readdata = 32'hDEAD_BEEF;
    step();
    chk1 ("f1_read",   read,       1'b1);
    chk1 ("f1_write",  write,      1'b0);
    chk1 ("f1_busy",   busy,       1'b1);
    chk32("f1_addr",   address,    32'h0000_1000);
    chk32("f1_be",     32'(byteenable), 32'hF);
    chk1 ("f1_nodone", if_done,    1'b0);
    step();
    chk1 ("f1_done",   if_done,    1'b1);
    chk1 ("f1_err",    if_err,     1'b0);
    chk32("f1_rdata",  if_rdata,   32'hDEAD_BEEF);
    chk1 ("f1_rdrop",  read,       1'b0);
    chk1 ("f1_idle",   busy,       1'b0);
    if_req = 1'b0;
    step();
    chk1 ("f1_pulse",  if_done,    1'b0);
    chk1 ("f1_noiss",  read,       1'b0);

    // Simultaneous data store and fetch: store first, then the fetch
    if_req   = 1'b1;
    if_addr  = 32'h0000_1004;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 32'h0000_2003;
    d_be     = 4'b1000;
    d_wdata  = 32'h1122_3344;
    readdata = 32'hCAFE_F00D;
    step();
    chk1 ("s_write",   write,      1'b1);
    chk1 ("s_read",    read,       1'b0);
    chk32("s_addr",    address,    32'h0000_2000);
    chk32("s_be",      32'(byteenable), 32'h8);
    chk32("s_wdata",   writedata,  32'h1122_3344);
    step();
    chk1 ("s_done",    d_done,     1'b1);
    chk1 ("s_err",     d_err,      1'b0);
    chk32("s_rdata",   d_rdata,    32'h0);
    chk1 ("s_ifquiet", if_done,    1'b0);
    d_req = 1'b0;
    step();
    chk1 ("sf_read",   read,       1'b1);
    chk1 ("sf_write",  write,      1'b0);
    chk32("sf_addr",   address,    32'h0000_1004);
    chk32("sf_be",     32'(byteenable), 32'hF);
    chk1 ("sf_dquiet", d_done,     1'b0);
    step();
    chk1 ("sf_done",   if_done,    1'b1);
    chk32("sf_rdata",  if_rdata,   32'hCAFE_F00D);
    chk1 ("sf_dquiet2", d_done,    1'b0);
    if_req = 1'b0;
    step();

    // Load stalled by waitrequest for three cycles
    d_req       = 1'b1;
    d_we        = 1'b0;
    d_addr      = 32'h0000_3008;
    d_be        = 4'b0011;
    waitrequest = 1'b1;
    readdata    = 32'h55AA_55AA;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk1 ($sformatf("w_read%0d", c), read,    1'b1);
      chk32($sformatf("w_addr%0d", c), address, 32'h0000_3008);
      chk1 ($sformatf("w_nodn%0d", c), d_done,  1'b0);
    end
    step();
    waitrequest = 1'b0;
    chk1 ("w_read4",   read,       1'b1);
    chk32("w_addr4",   address,    32'h0000_3008);
    chk32("w_be4",     32'(byteenable), 32'h3);
    chk1 ("w_nodn4",   d_done,     1'b0);
    step();
    chk1 ("w_done",    d_done,     1'b1);
    chk1 ("w_err",     d_err,      1'b0);
    chk32("w_rdata",   d_rdata,    32'h55AA_55AA);
    chk1 ("w_rdrop",   read,       1'b0);
    d_req = 1'b0;
    step();
    chk1 ("w_once",    d_done,     1'b0);
    chk1 ("w_noiss",   read,       1'b0);

    // Timeout after four stalled cycles
    d_req       = 1'b1;
    d_we        = 1'b0;
    d_addr      = 32'h0000_4000;
    d_be        = 4'b1111;
    waitrequest = 1'b1;
    readdata    = 32'h1234_5678;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk1 ($sformatf("t_read%0d", c), read,   1'b1);
      chk1 ($sformatf("t_nodn%0d", c), d_done, 1'b0);
    end
    step();
    chk1 ("t_rdrop",   read,       1'b0);
    chk1 ("t_idle",    busy,       1'b0);
    chk1 ("t_done",    d_done,     1'b1);
    chk1 ("t_err",     d_err,      1'b1);
    chk32("t_rdata",   d_rdata,    32'h0);
    d_req       = 1'b0;
    waitrequest = 1'b0;
    step();
    chk1 ("t_pulse",   d_done,     1'b0);
    chk1 ("t_errclr",  d_err,      1'b0);

    // Misaligned fetch: error without a bus cycle
    if_req   = 1'b1;
    if_addr  = 32'h0000_1002;
    readdata = 32'hFFFF_FFFF;
    step();
    chk1 ("m_read",    read,       1'b0);
    chk1 ("m_busy",    busy,       1'b0);
    chk1 ("m_done",    if_done,    1'b1);
    chk1 ("m_err",     if_err,     1'b1);
    chk32("m_rdata",   if_rdata,   32'h0);
    if_req = 1'b0;
    step();
    chk1 ("m_pulse",   if_done,    1'b0);
    chk1 ("m_noread",  read,       1'b0);

    // Reset during a stalled read
    d_req       = 1'b1;
    d_we        = 1'b0;
    d_addr      = 32'h0000_5000;
    waitrequest = 1'b1;
    step();
    chk1 ("r_read",    read,       1'b1);
    step();
    chk1 ("r_read2",   read,       1'b1);
    reset = 1'b1;
    step();
    chk1 ("r_rdrop",   read,       1'b0);
    chk1 ("r_idle",    busy,       1'b0);
    chk1 ("r_nodone",  d_done,     1'b0);
    reset       = 1'b0;
    d_req       = 1'b0;
    waitrequest = 1'b0;
    step();
    chk1 ("r_nodone2", d_done,     1'b0);
    chk1 ("r_noerr",   d_err,      1'b0);
    chk32("r_rdata",   d_rdata,    32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: WAIT_LIMIT, default 255, waitrequest cycles tolerated per transaction before abort; 0 disables timeout.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  instruction-fetch request, held high until if_done.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_rdata  out  32  fetched word, valid while if_done high.
REQ-007 if_done  out  1  one-cycle fetch completion pulse.
REQ-008 if_err  out  1  fetch error qualifier, valid while if_done high.
REQ-009 d_req  in  1  data request, held high until d_done.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  32  data byte address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_be  in  4  byte enables.
REQ-014 d_rdata, d_done, d_err  out  32/1/1  data-port equivalents of REQ-006..008.
REQ-015 busy  out  1  high whenever state is not IDLE; CPU state sequencer stalls on it.
REQ-016 address  out  32  bus word address.
REQ-017 read, write  out  1 each  bus strobes, never both high.
REQ-018 writedata  out  32  store data to bus.
REQ-019 byteenable  out  4  bus byte enables.
REQ-020 waitrequest  in  1  slave stall; transfer completes in a cycle with read|write high and waitrequest low.
REQ-021 readdata  in  32  read data, valid in the completion cycle.

Function
REQ-022 States IDLE, FETCH, DATA; held in a registered state variable.
REQ-023 IDLE: d_req accepted first (data priority), else if_req; acceptance latches address, we, wdata, be into holding registers.
REQ-024 A port's req is not accepted in the cycle its own done is high; prevents double issue, guarantees fetch service after each data access.
REQ-025 Accept in IDLE at edge N -> read/write high from cycle N+1; bus outputs driven only from holding registers, stable until completion.
REQ-026 Bus address = {held_addr[31:2], 2'b00}; byteenable = 4'b1111 for fetch, held d_be for data.
REQ-027 Completion cycle (waitrequest low): readdata captured into port rdata register; state -> IDLE; port done pulses high in the following cycle for exactly one cycle, err=0.
REQ-028 Minimum latency: req sampled in IDLE at edge N, done high in cycle N+2.
REQ-029 Store: d_rdata holds previous value; d_done still pulses.
REQ-030 Fetch with if_addr[1:0] != 0: no bus transaction; if_done and if_err pulse one cycle after acceptance, if_rdata = 0.
REQ-031 Timeout: WAIT_LIMIT consecutive waitrequest-high cycles -> strobes drop next cycle, state -> IDLE, done+err pulse, rdata = 0.
REQ-032 Requester dropping req mid-transaction: transaction completes normally, done still pulses.
REQ-033 Simultaneous if_req and d_req in IDLE: data served, fetch served immediately after (REQ-024).
REQ-034 if_done and d_done never high in the same cycle.

Reset
REQ-035 On reset: state IDLE, read=write=0, busy=0, all done/err=0, rdata registers=0, holding registers=0, wait counter=0.
REQ-036 Reset mid-transaction: strobes low on the next edge, pending transaction dropped, no done issued.

Structure
REQ-037 Shared package mips_bus_pkg holds the state enum (IDLE, FETCH, DATA) and the word-alignment mask constant.
REQ-038 One sub-module, bus_wait_timer: counter of waitrequest cycles with clear and expiry output, parameterised by WAIT_LIMIT.

Verification
REQ-039 if_req, if_addr=0x1000, waitrequest=0, readdata=0xDEADBEEF -> read high cycle N+1, if_done with if_rdata=0xDEADBEEF cycle N+2, if_err=0.
REQ-040 if_req and d_req both high (d_we=1, d_addr=0x2003, d_be=4'b1000, d_wdata=0x11223344) -> write first with address=0x2000, byteenable=4'b1000; d_done; then fetch read issued.
REQ-041 Load with waitrequest high 3 cycles -> address/read stable all 4 cycles, d_done exactly once after waitrequest drops.
REQ-042 WAIT_LIMIT=4, waitrequest stuck high -> read drops after 4 cycles, d_done=1, d_err=1, d_rdata=0.
REQ-043 if_addr=0x1002 -> no read strobe, if_done=1, if_err=1, if_rdata=0.
REQ-044 reset asserted during waitrequest-stalled read -> read=0, busy=0 next cycle, no done pulse.
